icache_nway: RTL and testbench

Parametrised N-way set-associative instruction cache with round-robin replacement and a walking flush. It sits between instruction fetch and instruction memory as the next-generation instruction cache top. Hits return in the request cycle; misses fetch one full line from memory and replay. All arrays are flop-based.

---
 rtl/icache_nway.sv | 199 +++++++++++++++++++
 tb/tb_icache_nway.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_nway.sv
// icache_nway: N-way set-associative instruction cache with flop-based arrays,
// round-robin replacement per set and a walking flush (one set per cycle).
// A hit acknowledges in the request cycle. A miss fetches one full line and
// then replays the request.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   imem_sel_i, req_i    fetch request, only valid while imem_sel_i is high
//   req_kill_i           abandon the current request
//   addr_i               byte address of the fetch; bits [1:0] are ignored
//   flush_i              one-cycle pulse that invalidates the whole cache
//   ack_o, rdata_o       instruction word returned this cycle
//   flush_busy_o         flush walk in progress
//   mem_req_o/addr_o     line fetch request, held until mem_ack_i
//   mem_ack_i/rdata_i    line returned; word k sits at bits [32k+31:32k]
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | lookup; a hit acks combinationally, a miss latches the address
// MISS    | line fetch outstanding; the line is written on mem_ack_i
// REPLAY  | ack from the freshly written line unless killed or flushing
// FLUSH   | clear the valid bits and rr pointer of one set per cycle
module icache_nway #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 64,
    parameter int WAYS       = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    imem_sel_i,
    input  logic                    req_i,
    input  logic                    req_kill_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic                    flush_i,
    output logic                    ack_o,
    output logic [31:0]             rdata_o,
    output logic                    flush_busy_o,
    output logic                    mem_req_o,
    output logic [ADDR_W-1:0]       mem_addr_o,
    input  logic                    mem_ack_i,
    input  logic [LINE_BYTES*8-1:0] mem_rdata_i
);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = OFF_W - 2;
    localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MISS, S_REPLAY, S_FLUSH} state_t;
    state_t state, state_nxt;

    logic [WAYS-1:0]   valid    [SETS];
    logic [RR_W-1:0]   rr_ptr   [SETS];
    logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
    logic [LINE_W-1:0] line_mem [SETS][WAYS];

    logic [IDX_W-1:0]  flush_cnt;
    logic              kill_q;
    logic              flush_pend_q;
    logic [ADDR_W-1:2] addr_q;
    logic [RR_W-1:0]   way_q;

    logic [TAG_W-1:0]  req_tag, q_tag;
    logic [IDX_W-1:0]  req_idx, q_idx;
    logic [WSEL_W-1:0] req_word, q_word, rd_word;
    logic              unused_addr_bits;

    assign req_tag  = addr_i[ADDR_W-1:OFF_W+IDX_W];
    assign req_idx  = addr_i[OFF_W+IDX_W-1:OFF_W];
    assign req_word = addr_i[OFF_W-1:2];
    assign q_tag    = addr_q[ADDR_W-1:OFF_W+IDX_W];
    assign q_idx    = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign q_word   = addr_q[OFF_W-1:2];
    assign unused_addr_bits = ^addr_i[1:0];

    logic              lookup, hit, flush_eff, fill;
    logic [RR_W-1:0]   hit_way, victim, rr_inc;
    logic [LINE_W-1:0] rd_line;
    logic [31:0]       word;

    assign lookup    = req_i & imem_sel_i & ~req_kill_i;
    // A flush arriving in the same cycle as the line return already counts.
    assign flush_eff = flush_pend_q | flush_i;
    assign fill      = (state == S_MISS) & mem_ack_i & ~flush_eff;
    assign victim    = rr_ptr[q_idx];
    assign rr_inc    = (victim == RR_W'(WAYS - 1)) ? '0 : victim + 1'b1;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = RR_W'(w);
            end
        end
    end

    // REPLAY reads back the line just written at the latched address.
    assign rd_line = (state == S_REPLAY) ? line_mem[q_idx][way_q] : line_mem[req_idx][hit_way];
    assign rd_word = (state == S_REPLAY) ? q_word : req_word;
    assign word    = rd_line[{rd_word, 5'b00000} +: 32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            flush_cnt    <= '0;
            kill_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            addr_q       <= '0;
            way_q        <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s]  <= '0;
                rr_ptr[s] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && state_nxt == S_MISS)
                addr_q <= addr_i[ADDR_W-1:2];
            if (fill) begin
                valid[q_idx][victim] <= 1'b1;
                rr_ptr[q_idx]        <= rr_inc;
                way_q                <= victim;
            end
            if (state == S_MISS && req_kill_i)
                kill_q <= 1'b1;
            if ((state == S_MISS || state == S_REPLAY) && flush_i)
                flush_pend_q <= 1'b1;
            if (state == S_FLUSH) begin
                valid[flush_cnt]  <= '0;
                rr_ptr[flush_cnt] <= '0;
                flush_cnt         <= flush_cnt + 1'b1;
            end
            if (state_nxt == S_IDLE)
                kill_q <= 1'b0;
            // Pending flush is consumed once the walk starts (or on return to IDLE).
            if (state_nxt == S_IDLE || state_nxt == S_FLUSH)
                flush_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_mem[q_idx][victim]  <= q_tag;
            line_mem[q_idx][victim] <= mem_rdata_i;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (flush_i)
                    state_nxt = S_FLUSH;
                else if (lookup && !hit)
                    state_nxt = S_MISS;
            end
            S_MISS: begin
                if (mem_ack_i)
                    state_nxt = flush_eff ? S_FLUSH : S_REPLAY;
            end
            S_REPLAY: state_nxt = flush_eff ? S_FLUSH : S_IDLE;
            S_FLUSH: begin
                if (flush_cnt == IDX_W'(SETS - 1))
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ack_o        = 1'b0;
        rdata_o      = '0;
        mem_req_o    = 1'b0;
        flush_busy_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (lookup && hit && !flush_i) begin
                    ack_o   = 1'b1;
                    rdata_o = word;
                end
            end
            S_MISS: mem_req_o = 1'b1;
            S_REPLAY: begin
                if (lookup && !kill_q && !flush_eff) begin
                    ack_o   = 1'b1;
                    rdata_o = word;
                end
            end
            S_FLUSH: flush_busy_o = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr_o = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

endmodule

// File: tb/tb_icache_nway.sv
module tb_icache_nway;
    localparam int SETS = 64;
    localparam int WAYS = 2;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         imem_sel_i = 1'b1;
    logic         req_i = 1'b0;
    logic         req_kill_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic         flush_i = 1'b0;
    logic         ack_o;
    logic [31:0]  rdata_o;
    logic         flush_busy_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ack_i = 1'b0;
    logic [127:0] mem_rdata_i = '0;

    icache_nway #(.ADDR_W(32), .LINE_BYTES(16), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .imem_sel_i(imem_sel_i), .req_i(req_i),
        .req_kill_i(req_kill_i), .addr_i(addr_i), .flush_i(flush_i), .ack_o(ack_o),
        .rdata_o(rdata_o), .flush_busy_o(flush_busy_o), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: which lines are resident, tracked per set/way.
    bit          m_valid[SETS][WAYS];
    logic [21:0] m_tag[SETS][WAYS];
    int          m_rr[SETS];

    function automatic bit m_hit(input logic [31:0] a);
        int s = int'(a[9:4]);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[31:10]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_fill(input logic [31:0] a);
        int s = int'(a[9:4]);
        m_valid[s][m_rr[s]] = 1'b1;
        m_tag[s][m_rr[s]]   = a[31:10];
        m_rr[s]             = (m_rr[s] + 1) % WAYS;
    endtask

    task automatic m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] la, input int k);
        if (la == 32'h1000) return 32'h11 * 32'(k + 1);
        return la ^ (32'h1357_9BDF * 32'(k + 1));
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = mem_word(la, k);
        return l;
    endfunction

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (ack_o) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", rdata_o, e.data);
                chk("ack_cycle", cyc_cnt, e.cyc);
            end
        end
    end

    // Issue one fetch; on a miss the memory answers lat cycles after mem_req_o rises.
    task automatic fetch(input logic [31:0] a, input int lat, input int kill_at, input int flush_at);
        logic [31:0] la = {a[31:4], 4'h0};
        bit hit = m_hit(a);
        int start = cyc_cnt;
        int busy = 0;
        bit killed, flushed;
        exp_t e;
        req_i = 1'b1; imem_sel_i = 1'b1; addr_i = a;
        e.data = mem_word(la, int'(a[3:2]));
        if (hit) begin
            e.cyc = start;
            sb.push_back(e);
            @(negedge clk_i);
            @(posedge clk_i); #1;
            req_i = 1'b0;
            return;
        end
        killed  = kill_at >= 1 && kill_at <= lat + 1;
        flushed = flush_at >= 1 && flush_at <= lat + 1;
        if (!killed && !flushed) begin
            e.cyc = start + lat + 2;
            sb.push_back(e);
        end
        for (int c = 0; c <= lat + 2; c++) begin
            req_kill_i  = (c == kill_at);
            flush_i     = (c == flush_at);
            mem_ack_i   = (c == lat + 1);
            mem_rdata_i = (c == lat + 1) ? mem_line(la) : {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk_i);
            chk("mem_req", {31'd0, mem_req_o}, {31'd0, (c >= 1 && c <= lat + 1)});
            if (c >= 1 && c <= lat + 1) chk("mem_addr", mem_addr_o, la);
            if (flush_busy_o) busy++;
            @(posedge clk_i); #1;
        end
        req_i = 1'b0; req_kill_i = 1'b0; flush_i = 1'b0; mem_ack_i = 1'b0;
        if (flushed) begin
            for (int i = 0; i < SETS + 8; i++) begin
                @(negedge clk_i);
                if (!flush_busy_o) break;
                busy++;
                @(posedge clk_i); #1;
            end
            @(posedge clk_i); #1;
            m_clear();
        end else begin
            m_fill(a);
        end
        chk("refill_flush_len", busy, flushed ? SETS : 0);
    endtask

    // Flush pulse, optionally with a request held throughout (must never ack).
    task automatic do_flush(input logic [31:0] a, input bit with_req);
        int cnt = 0;
        flush_i = 1'b1; req_i = with_req; imem_sel_i = 1'b1; addr_i = a;
        @(negedge clk_i);
        chk("flush_busy_c0", {31'd0, flush_busy_o}, 32'd0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        for (int i = 0; i < SETS; i++) begin
            @(negedge clk_i);
            if (flush_busy_o) cnt++;
            @(posedge clk_i); #1;
        end
        req_i = 1'b0;
        @(negedge clk_i);
        if (flush_busy_o) cnt++;
        @(posedge clk_i); #1;
        chk("flush_len", cnt, SETS);
        m_clear();
    endtask

    task automatic nosel(input logic [31:0] a);
        req_i = 1'b1; imem_sel_i = 1'b0; addr_i = a;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        req_i = 1'b0; imem_sel_i = 1'b1;
        @(negedge clk_i);
        chk("nosel_mem_req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_i); #1;
    endtask

    task automatic reset_mid_refill(input logic [31:0] a);
        req_i = 1'b1; imem_sel_i = 1'b1; addr_i = a;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rst_pre_mem_req", {31'd0, mem_req_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_busy", {31'd0, flush_busy_o}, 32'd0);
        req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        mem_ack_i = 1'b1; mem_rdata_i = mem_line({a[31:4], 4'h0});
        @(negedge clk_i);
        chk("stale_ack_mem_req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        m_clear();
        fetch(a, 2, -1, -1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int lat, km, fm, r;
        m_clear();
        #3;
        chk("reset_ack", {31'd0, ack_o}, 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);
        chk("reset_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("reset_mem_addr", mem_addr_o, 32'd0);
        chk("reset_busy", {31'd0, flush_busy_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // cold miss then same-line hit
        fetch(32'h1004, 3, -1, -1);
        fetch(32'h100C, 0, -1, -1);
        // conflict and round-robin replacement in set 0
        fetch(32'h2000, 1, -1, -1);
        fetch(32'h1000, 0, -1, -1);
        fetch(32'h2004, 0, -1, -1);
        fetch(32'h3000, 2, -1, -1);
        fetch(32'h2008, 0, -1, -1);
        fetch(32'h1000, 1, -1, -1);
        // kill during refill: line still installed, no ack
        do_flush(32'h1000, 1'b1);
        fetch(32'h1000, 3, 2, -1);
        fetch(32'h1000, 0, -1, -1);
        // flush with resident lines; same-cycle hit request gets no ack
        fetch(32'h2000, 1, -1, -1);
        do_flush(32'h1000, 1'b1);
        fetch(32'h1000, 1, -1, -1);
        fetch(32'h2000, 1, -1, -1);
        // flush during refill
        do_flush(32'h0, 1'b0);
        fetch(32'h1000, 3, -1, 2);
        fetch(32'h1000, 1, -1, -1);
        // imem_sel low and reset mid refill
        nosel(32'h7770);
        do_flush(32'h0, 1'b0);
        reset_mid_refill(32'h1000);

        for (int t = 0; t < 300; t++) begin
            a = (32'($urandom_range(1, 5)) << 10) | (32'($urandom_range(0, 3)) << 4)
                | 32'($urandom_range(0, 15));
            lat = $urandom_range(0, 4);
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_flush(a, 1'($urandom_range(0, 1)));
            end else if (r < 8) begin
                nosel(a);
            end else begin
                km = -1; fm = -1;
                if (!m_hit(a)) begin
                    r = $urandom_range(0, 99);
                    if (r < 12) km = $urandom_range(1, lat + 1);
                    else if (r < 18) fm = $urandom_range(1, lat + 1);
                end
                fetch(a, lat, km, fm);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk_i); #1;
            end
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
